lcd8080_apb_bridge: RTL and testbench
=====================================

Name: lcd8080_apb_bridge

Overview:
- APB slave driving an 8080-style parallel LCD bus (csel/rs/wr/rd, active-low strobes).
- Generalised successor to the fixed 16-bit single-transfer LCD adapter: parametrised data width, posted-write FIFO, runtime-programmable timing, status register, chip-select held low across back-to-back bursts.
- Sits on the SoC APB segment between the CPU's APB bridge and the LCD panel pins.

Parameters:
- DATA_W, 16, LCD bus width (8..16).
- FIFO_DEPTH, 8, posted-write FIFO entries; power of two, >= 2.
- CNT_W, 9, width of timing counters and timing fields.
- RS_RST, 3, reset value of setup time (cycles, rs/csel valid before strobe).
- WR_RST, 5, reset value of wr low time.
- RD_RST, 50, reset value of rd low time; sample point.
- HOLD_RST, 5, reset value of strobe-high recovery time.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- APB_paddr  in  32  byte address; only [3:2] decoded
- APB_psel  in  1  select
- APB_penable  in  1  access phase
- APB_pwrite  in  1  1 = write
- APB_pwdata  in  32  write data
- APB_pready  out  1  transfer complete
- APB_prdata  out  32  read data
- APB_pslverr  out  1  error response
- LCD_nrst  out  1  equals nrst
- LCD_csel  out  1  chip select, active low
- LCD_rs  out  1  0 = command, 1 = data
- LCD_wr  out  1  write strobe, active low
- LCD_rd  out  1  read strobe, active low
- LCD_data_in  in  DATA_W  panel read data
- LCD_data_out  out  DATA_W  panel write data
- LCD_data_z  out  DATA_W  per-bit tristate enable, 1 = hi-Z

Behaviour:
- Registers at paddr[3:2]:
  - 0 = CMD: write posts {rs=0,data}; read performs a panel read with rs=0.
  - 1 = DATA: same with rs=1.
  - 2 = STATUS (RO): [0] busy, [1] fifo_full, [2] fifo_empty, [15:8] fifo level.
  - 3 = TIMING (RW): [8:0] rs, [17:9] wr, [26:18] rd, still within CNT_W each; hold in a second write? No: TIMING holds rs/wr/rd; hold is fixed to HOLD_RST.
- Timing field value 0 is treated as 1. TIMING writes take effect at the next SETUP entry; an in-flight transfer is never altered.
- Reset values: csel=1, wr=1, rd=1, rs=0, data_z=all 1, data_out=0, prdata=0, pready=0, pslverr=0; FIFO empty; TIMING = RS_RST/WR_RST/RD_RST. Reset mid-transfer aborts immediately, flushes FIFO, returns to reset values.
- APB access phase = psel & penable. pready is asserted for exactly one access-phase cycle per transfer; prdata is valid in that cycle.
- CMD/DATA write: pready in the same cycle if FIFO not full, entry pushed in that cycle. If FIFO full, pready stays low until an entry pops; the push happens in the pready cycle.
- CMD/DATA read: wait until FIFO empty and sequencer IDLE, then run a read transfer; pready is asserted the cycle after the HOLD phase ends; prdata = zero-extended sample.
- STATUS/TIMING access: pready in the first access cycle (zero wait).
- Write to STATUS: pready=1, pslverr=1, no effect. pslverr is 0 in all other cases.
- Sequencer FSM:
  - IDLE: on FIFO non-empty or pending read -> SETUP. Latch rs, and for writes data_out with data_z=0. csel=0.
  - SETUP: count rs cycles -> STROBE; drive wr=0 (write) or rd=0 (read).
  - STROBE: count wr or rd cycles. On the last cycle, release the strobe to 1; a read samples LCD_data_in on this cycle. -> HOLD.
  - HOLD: count HOLD_RST cycles. If the FIFO is non-empty at the end -> SETUP with csel kept 0 (burst). Otherwise csel=1, data_z=all 1 -> IDLE.
- Counter semantics: a phase programmed N lasts exactly N clk cycles.
- Pops occur on IDLE->SETUP or HOLD->SETUP. A simultaneous push and pop on a full FIFO is legal: the write completes that cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. Level is in 0..FIFO_DEPTH.
- busy = sequencer not IDLE or FIFO non-empty.

Test Plan:
- Reset -> all LCD outputs at the reset values above. Write CMD 0x2C -> pready same cycle; csel low. After 3 cycles wr low for 5 cycles with data_out=0x002C, rs=0. After 5 hold cycles csel high.
- Write DATA 0x1234 then 0x5678 back-to-back -> csel low continuously across both transfers; two wr pulses, 5 low / 5+3 high between, rs=1.
- Write FIFO_DEPTH+1 DATA words with TIMING slowed -> last write holds pready low until the first pop, then completes; STATUS level never exceeds 8.
- Queue 2 writes, then read CMD with LCD_data_in=0xA5A5 -> read starts only after both writes; rd low 50 cycles; prdata=0x0000A5A5.
- Write TIMING rs=1, wr=1, hold default; write DATA -> wr low exactly 1 cycle after 1 setup cycle. Write STATUS -> pslverr=1.
- Assert nrst during STROBE of a queued burst -> outputs return to reset values asynchronously; STATUS after reset = empty, not busy.

Source files
------------

// File: rtl/lcd8080_apb_bridge_if.sv
// rtl/lcd8080_apb_bridge_if.sv - APB register bus bundle for the 8080 LCD bridge
//
// Purpose : groups the APB slave signals of lcd8080_apb_bridge into one port.
// Signals : paddr   byte address (only [3:2] decoded by the bridge)
//           psel    select
//           penable access phase
//           pwrite  1 = write
//           pwdata  write data
//           pready  transfer complete (slave output)
//           prdata  read data, valid while pready (slave output)
//           pslverr error response (slave output)
// Modports: master drives the request side, slave drives the response side.

interface lcd8080_apb_bridge_if;

    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr,
        output psel,
        output penable,
        output pwrite,
        output pwdata,
        input  pready,
        input  prdata,
        input  pslverr
    );

    modport slave (
        input  paddr,
        input  psel,
        input  penable,
        input  pwrite,
        input  pwdata,
        output pready,
        output prdata,
        output pslverr
    );

endinterface

// File: rtl/lcd8080_apb_bridge.sv
// rtl/lcd8080_apb_bridge.sv - APB slave driving an 8080-style parallel LCD bus
//
// Purpose : posted-write FIFO in front of a csel/rs/wr/rd strobe sequencer with
//           runtime-programmable setup/strobe lengths and a status register.
// Ports   : clk, nrst          clock, asynchronous active-low reset
//           apb                APB slave (lcd8080_apb_bridge_if.slave)
//           LCD_nrst           copy of nrst for the panel
//           LCD_csel           chip select, active low
//           LCD_rs             0 = command, 1 = data
//           LCD_wr / LCD_rd    write / read strobes, active low
//           LCD_data_in        panel read data
//           LCD_data_out       panel write data
//           LCD_data_z         per-bit tristate enable, 1 = hi-Z
// Registers (paddr[3:2]):
//           0 CMD    write posts {rs=0,data}; read runs a panel read with rs=0
//           1 DATA   as CMD with rs=1
//           2 STATUS RO: [0] busy, [1] fifo_full, [2] fifo_empty, [15:8] level
//           3 TIMING RW: setup, wr-low, rd-low fields of CNT_W bits each

module lcd8080_apb_bridge #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 9,
    parameter int RS_RST     = 3,
    parameter int WR_RST     = 5,
    parameter int RD_RST     = 50,
    parameter int HOLD_RST   = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    lcd8080_apb_bridge_if.slave   apb,
    output logic                  LCD_nrst,
    output logic                  LCD_csel,
    output logic                  LCD_rs,
    output logic                  LCD_wr,
    output logic                  LCD_rd,
    input  logic [DATA_W-1:0]     LCD_data_in,
    output logic [DATA_W-1:0]     LCD_data_out,
    output logic [DATA_W-1:0]     LCD_data_z
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_W + 1;

    // Counters are loaded with length-1 so a phase programmed N lasts N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_RST > 1) ? CNT_W'(HOLD_RST - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    // A programmed length of 0 behaves like 1.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Timing register
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] rs_t;
    logic [CNT_W-1:0] wr_t;
    logic [CNT_W-1:0] rd_t;

    // ------------------------------------------------------------------
    // FIFO storage and state
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] head;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] strobe_len;
    logic             is_read;
    logic             rd_ack;
    logic [DATA_W-1:0] rd_data;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic       access;
    logic [1:0] reg_sel;
    logic       fifo_reg;
    logic       pop;
    logic       push;
    logic       rd_start;
    logic       timing_wr;
    logic       busy;
    logic [31:0] status_word;
    logic [31:0] timing_word;
    logic [7:0] level8;
    logic       unused_bits;

    assign access   = apb.psel & apb.penable;
    assign reg_sel  = apb.paddr[3:2];
    assign fifo_reg = ~reg_sel[1];

    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign head       = mem[rd_ptr];

    // Entries leave the FIFO only when the sequencer starts a new SETUP.
    assign pop = ~fifo_empty &
                 ((state == S_IDLE) | ((state == S_HOLD) & (cnt == '0)));

    // A full FIFO still accepts the write in the cycle that frees a slot.
    assign push = access & apb.pwrite & fifo_reg & (~fifo_full | pop);

    // rd_ack blocks a second read from starting in the cycle the first
    // one completes, while the master still holds the access phase.
    assign rd_start = access & ~apb.pwrite & fifo_reg & fifo_empty &
                      (state == S_IDLE) & ~rd_ack;

    assign timing_wr = access & apb.pwrite & (reg_sel == 2'd3);

    assign busy   = (state != S_IDLE) | ~fifo_empty;
    assign level8 = 8'(level);

    assign status_word = {16'h0000, level8, 5'b00000, fifo_empty, fifo_full, busy};
    assign timing_word = 32'({rd_t, wr_t, rs_t});

    assign apb.pready = access &
                        (reg_sel[1] | (apb.pwrite ? (~fifo_full | pop) : rd_ack));

    assign apb.pslverr = access & apb.pwrite & (reg_sel == 2'd2);

    always_comb begin
        apb.prdata = '0;
        if (apb.pready && !apb.pwrite) begin
            case (reg_sel)
                2'd2:    apb.prdata = status_word;
                2'd3:    apb.prdata = timing_word;
                default: apb.prdata = 32'(rd_data);
            endcase
        end
    end

    assign LCD_nrst = nrst;

    assign unused_bits = ^{apb.paddr[31:4], apb.paddr[1:0], apb.pwdata[31:3*CNT_W]};

    // ------------------------------------------------------------------
    // Timing register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rs_t <= CNT_W'(RS_RST);
            wr_t <= CNT_W'(WR_RST);
            rd_t <= CNT_W'(RD_RST);
        end else if (timing_wr) begin
            rs_t <= apb.pwdata[CNT_W-1:0];
            wr_t <= apb.pwdata[2*CNT_W-1:CNT_W];
            rd_t <= apb.pwdata[3*CNT_W-1:2*CNT_W];
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {apb.paddr[2], apb.pwdata[DATA_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobe sequencer. Strobe and setup lengths are captured on every
    // SETUP entry so a TIMING write never disturbs a transfer in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            strobe_len   <= '0;
            is_read      <= 1'b0;
            rd_ack       <= 1'b0;
            rd_data      <= '0;
            LCD_csel     <= 1'b1;
            LCD_rs       <= 1'b0;
            LCD_wr       <= 1'b1;
            LCD_rd       <= 1'b1;
            LCD_data_out <= '0;
            LCD_data_z   <= '1;
        end else begin
            rd_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state        <= S_SETUP;
                        LCD_csel     <= 1'b0;
                        LCD_rs       <= head[DATA_W];
                        LCD_data_out <= head[DATA_W-1:0];
                        LCD_data_z   <= '0;
                        is_read      <= 1'b0;
                        cnt          <= load_val(rs_t);
                        strobe_len   <= load_val(wr_t);
                    end else if (rd_start) begin
                        state      <= S_SETUP;
                        LCD_csel   <= 1'b0;
                        LCD_rs     <= apb.paddr[2];
                        is_read    <= 1'b1;
                        cnt        <= load_val(rs_t);
                        strobe_len <= load_val(rd_t);
                    end
                end

                S_SETUP: begin
                    if (cnt == '0) begin
                        state <= S_STROBE;
                        cnt   <= strobe_len;
                        if (is_read) begin
                            LCD_rd <= 1'b0;
                        end else begin
                            LCD_wr <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_STROBE: begin
                    if (cnt == '0) begin
                        // Last low cycle: the panel data is sampled here and
                        // the strobe rises on the following edge.
                        state  <= S_HOLD;
                        cnt    <= HOLD_LOAD;
                        LCD_wr <= 1'b1;
                        LCD_rd <= 1'b1;
                        if (is_read) begin
                            rd_data <= LCD_data_in;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_HOLD: begin
                    if (cnt == '0) begin
                        if (!fifo_empty) begin
                            // Burst: csel stays low into the next transfer.
                            state        <= S_SETUP;
                            LCD_rs       <= head[DATA_W];
                            LCD_data_out <= head[DATA_W-1:0];
                            LCD_data_z   <= '0;
                            is_read      <= 1'b0;
                            cnt          <= load_val(rs_t);
                            strobe_len   <= load_val(wr_t);
                        end else begin
                            state      <= S_IDLE;
                            LCD_csel   <= 1'b1;
                            LCD_data_z <= '1;
                            rd_ack     <= is_read;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd8080_apb_bridge.sv
// tb/tb_lcd8080_apb_bridge.sv - directed self-checking bench for lcd8080_apb_bridge

module tb_lcd8080_apb_bridge;

    localparam int TR_N = 8192;

    logic        clk = 1'b0;
    logic        nrst;
    logic        lcd_nrst;
    logic        lcd_csel;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic [15:0] lcd_data_in;
    logic [15:0] lcd_data_out;
    logic [15:0] lcd_data_z;

    int checks = 0;
    int errors = 0;

    lcd8080_apb_bridge_if bus();

    lcd8080_apb_bridge dut (
        .clk          (clk),
        .nrst         (nrst),
        .apb          (bus),
        .LCD_nrst     (lcd_nrst),
        .LCD_csel     (lcd_csel),
        .LCD_rs       (lcd_rs),
        .LCD_wr       (lcd_wr),
        .LCD_rd       (lcd_rd),
        .LCD_data_in  (lcd_data_in),
        .LCD_data_out (lcd_data_out),
        .LCD_data_z   (lcd_data_z)
    );

    always #5 clk = ~clk;

    // Per-cycle trace of the panel pins: {all_z, csel, rs, wr, rd}
    logic [4:0]  tr_ctl [0:TR_N-1];
    logic [15:0] tr_do  [0:TR_N-1];
    int ncyc = 0;

    always @(negedge clk) begin
        if (ncyc < TR_N) begin
            tr_ctl[ncyc] <= {&lcd_data_z, lcd_csel, lcd_rs, lcd_wr, lcd_rd};
            tr_do[ncyc]  <= lcd_data_out;
        end
        ncyc <= ncyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int find(input int bitn, input logic val, input int from);
        if (from < 0) return -1;
        for (int i = from; i < ncyc && i < TR_N; i++) begin
            if (tr_ctl[i][bitn] == val) return i;
        end
        return -1;
    endfunction

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        @(posedge clk) #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(posedge clk) #1;
        bus.penable = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.pready && waits < 3000) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.pready) check("apb_timeout", 32'd0, 32'd1);
        rdata = bus.prdata;
        err   = bus.pslverr;
        @(posedge clk) #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data,
                          output int waits, output logic err);
        logic [31:0] rd;
        apb_xfer(1'b1, addr, data, rd, err, waits);
    endtask

    task automatic rd_reg(input logic [31:0] addr, output logic [31:0] data);
        logic e;
        int   w;
        apb_xfer(1'b0, addr, 32'h0, data, e, w);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n;
        s = 32'h1;
        n = 0;
        while (s[0] && n < 300) begin
            rd_reg(32'h8, s);
            n++;
        end
        check("wait_idle", {31'h0, s[0]}, 32'h0);
    endtask

    // Setup / strobe / hold lengths of the first write transfer after 'from'.
    task automatic measure(input int from, output int setup, output int strobe, output int hold,
                           output int i_strobe);
        int i0, i1, i2, i3;
        i0 = find(3, 1'b0, from);
        i1 = find(1, 1'b0, i0);
        i2 = find(1, 1'b1, i1);
        i3 = find(3, 1'b1, i2);
        setup    = (i0 < 0 || i1 < 0) ? -1 : i1 - i0;
        strobe   = (i1 < 0 || i2 < 0) ? -1 : i2 - i1;
        hold     = (i2 < 0 || i3 < 0) ? -1 : i3 - i2;
        i_strobe = i1;
    endtask

    initial begin
        int st, su, sb, ho, is, w, maxw, nwr;
        int i0, i1, i2, i4, i5, i6;
        logic e;
        logic [31:0] r;

        nrst        = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h0;
        bus.pwdata  = 32'h0;
        lcd_data_in = 16'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_csel", {31'h0, lcd_csel}, 32'h1);
        check("rst_wr_rd_rs", {29'h0, lcd_wr, lcd_rd, lcd_rs}, 32'h6);
        check("rst_data_z", {16'h0, lcd_data_z}, 32'h0000FFFF);
        check("rst_data_out", {16'h0, lcd_data_out}, 32'h0);
        check("rst_apb", {bus.prdata[30:0], bus.pready | bus.pslverr}, 32'h0);
        check("rst_lcd_nrst", {31'h0, lcd_nrst}, 32'h0);
        nrst = 1'b1;
        @(negedge clk);
        check("lcd_nrst_rel", {31'h0, lcd_nrst}, 32'h1);

        // Single CMD write
        st = ncyc;
        wr_reg(32'h0, 32'h0000002C, w, e);
        check("cmd_wait", w, 32'd0);
        check("cmd_err", {31'h0, e}, 32'h0);
        repeat (25) @(posedge clk);
        measure(st, su, sb, ho, is);
        check("cmd_setup", su, 32'd3);
        check("cmd_wr_low", sb, 32'd5);
        check("cmd_hold", ho, 32'd5);
        check("cmd_data", (is < 0) ? 32'hDEAD : {16'h0, tr_do[is]}, 32'h002C);
        check("cmd_rs", (is < 0) ? 32'hDEAD : {31'h0, tr_ctl[is][2]}, 32'h0);

        // Back-to-back DATA writes form a burst
        st = ncyc;
        wr_reg(32'h4, 32'h00001234, w, e);
        wr_reg(32'h4, 32'h00005678, w, e);
        repeat (40) @(posedge clk);
        i0 = find(3, 1'b0, st);
        i1 = find(1, 1'b0, i0);
        i2 = find(1, 1'b1, i1);
        i4 = find(1, 1'b0, i2);
        i5 = find(1, 1'b1, i4);
        i6 = find(3, 1'b1, i0);
        check("burst_wr1_low", (i1 < 0 || i2 < 0) ? -1 : i2 - i1, 32'd5);
        check("burst_gap", (i2 < 0 || i4 < 0) ? -1 : i4 - i2, 32'd8);
        check("burst_wr2_low", (i4 < 0 || i5 < 0) ? -1 : i5 - i4, 32'd5);
        check("burst_csel_cont", (i5 < 0 || i6 < 0) ? -1 : i6 - i5, 32'd5);
        check("burst_d1", (i1 < 0) ? 32'hDEAD : {15'h0, tr_ctl[i1][2], tr_do[i1]}, 32'h00011234);
        check("burst_d2", (i4 < 0) ? 32'hDEAD : {15'h0, tr_ctl[i4][2], tr_do[i4]}, 32'h00015678);

        // FIFO fill with slowed timing
        wr_reg(32'hC, 32'h00C82814, w, e);
        rd_reg(32'hC, r);
        check("timing_rb", r, 32'h00C82814);
        maxw = 0;
        for (int k = 0; k < 9; k++) begin
            wr_reg(32'h4, 32'h100 + k, w, e);
            if (w > maxw) maxw = w;
        end
        check("fill_no_wait", maxw, 32'd0);
        rd_reg(32'h8, r);
        check("status_full", r, 32'h00000803);
        wr_reg(32'h4, 32'h000001FF, w, e);
        check("full_write_waited", {31'h0, w > 0}, 32'h1);
        rd_reg(32'h8, r);
        check("status_full_again", r, 32'h00000803);
        wait_idle();

        // Read after queued writes
        wr_reg(32'hC, 32'h00C80A03, w, e);
        lcd_data_in = 16'hA5A5;
        st = ncyc;
        wr_reg(32'h0, 32'h00000011, w, e);
        wr_reg(32'h4, 32'h00000022, w, e);
        rd_reg(32'h0, r);
        check("read_data", r, 32'h0000A5A5);
        repeat (4) @(posedge clk);
        i0 = find(0, 1'b0, st);
        i1 = find(0, 1'b1, i0);
        nwr = 0;
        for (int i = st + 1; i <= i0 && i0 > 0; i++) begin
            if (tr_ctl[i][1] == 1'b0 && tr_ctl[i-1][1] == 1'b1) nwr++;
        end
        check("read_after_writes", nwr, 32'd2);
        check("read_rd_low", (i0 < 0 || i1 < 0) ? -1 : i1 - i0, 32'd50);
        check("read_rs_z", (i0 < 0) ? 32'hDEAD : {30'h0, tr_ctl[i0][4], tr_ctl[i0][2]}, 32'h2);

        // Minimum timing, and zero treated as one
        wr_reg(32'hC, 32'h00C80201, w, e);
        st = ncyc;
        wr_reg(32'h4, 32'h000000AB, w, e);
        repeat (15) @(posedge clk);
        measure(st, su, sb, ho, is);
        check("min_setup", su, 32'd1);
        check("min_wr_low", sb, 32'd1);
        check("min_hold", ho, 32'd5);
        wr_reg(32'hC, 32'h00C80000, w, e);
        rd_reg(32'hC, r);
        check("timing_zero_rb", r, 32'h00C80000);
        st = ncyc;
        wr_reg(32'h4, 32'h000000CD, w, e);
        repeat (15) @(posedge clk);
        measure(st, su, sb, ho, is);
        check("zero_setup", su, 32'd1);
        check("zero_wr_low", sb, 32'd1);

        // STATUS write error
        wr_reg(32'h8, 32'hFFFFFFFF, w, e);
        check("status_wr_err", {31'h0, e}, 32'h1);
        check("status_wr_wait", w, 32'd0);
        rd_reg(32'h8, r);
        check("status_idle", r, 32'h00000004);

        // Reset during a queued burst
        wr_reg(32'hC, 32'h00C80A03, w, e);
        wr_reg(32'h4, 32'h00003333, w, e);
        wr_reg(32'h4, 32'h00004444, w, e);
        wr_reg(32'h4, 32'h00005555, w, e);
        w = 0;
        @(negedge clk);
        while (lcd_wr && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("strobe_seen", {31'h0, lcd_wr}, 32'h0);
        #2 nrst = 1'b0;
        #1;
        check("arst_csel_wr_rd_rs", {28'h0, lcd_csel, lcd_wr, lcd_rd, lcd_rs}, 32'hE);
        check("arst_data_z", {16'h0, lcd_data_z}, 32'h0000FFFF);
        check("arst_data_out", {16'h0, lcd_data_out}, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        rd_reg(32'h8, r);
        check("arst_status", r, 32'h00000004);
        rd_reg(32'hC, r);
        check("arst_timing", r, 32'h00C80A03);
        repeat (20) @(posedge clk);
        #1;
        check("arst_no_restart", {31'h0, lcd_csel}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
